// File: rtl/cache_pkg.sv
// Shared types and sizes for the cache/memory side of the CPU.
// The arbiter state encoding lives here so benches and debug logic agree on it.
package cache_pkg;

  localparam int BLK_ADDR_W = 28;
  localparam int LINE_W     = 128;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Signal bundle around the memory arbiter: I-cache port, D-cache port and the shared memory port.
// master is the arbiter's view; slave is the view of the caches plus the memory model.
interface mem_arbiter_if #(
  parameter int ADDR_W = cache_pkg::BLK_ADDR_W,
  parameter int DATA_W = cache_pkg::LINE_W
);

  logic              i_mem_read;
  logic [ADDR_W-1:0] i_mem_addr;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              i_mem_ready;

  logic              d_mem_read;
  logic              d_mem_write;
  logic [ADDR_W-1:0] d_mem_addr;
  logic [DATA_W-1:0] d_mem_wdata;
  logic [DATA_W-1:0] d_mem_rdata;
  logic              d_mem_ready;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    input  i_mem_read, i_mem_addr,
    output i_mem_rdata, i_mem_ready,
    input  d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
    output d_mem_rdata, d_mem_ready,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    output i_mem_read, i_mem_addr,
    input  i_mem_rdata, i_mem_ready,
    output d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
    input  d_mem_rdata, d_mem_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the I-cache and D-cache.
// One request is latched at grant, run to mem_ready, then the other side gets first refusal.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ARB_IDLE  | no transaction in flight; arbitrate on the next edge
//   ARB_GNT_I | I-cache read latched and driven to memory
//   ARB_GNT_D | D-cache read or write-back latched and driven to memory
module mem_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_W  = BLK_ADDR_W,
  parameter int DATA_W  = LINE_W,
  parameter bit D_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           proc_reset_n,
  mem_arbiter_if.master  bus
);

  // last_gnt = 1 means D was granted last, so an initial value of ~D_FIRST favours D_FIRST.
  localparam logic LAST_GNT_RST = ~D_FIRST;

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic              last_gnt;
  logic              op_wr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic req_i;
  logic req_d;
  logic gnt_i;
  logic gnt_d;
  logic busy;

  function automatic logic pick_d(input logic ri, input logic rd, input logic last_d);
    return rd & (~ri | ~last_d);
  endfunction

  always_comb begin
    req_i     = bus.i_mem_read;
    req_d     = bus.d_mem_read | bus.d_mem_write;
    state_nxt = state;
    gnt_i     = 1'b0;
    gnt_d     = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (req_i || req_d) begin
          if (pick_d(req_i, req_d, last_gnt)) gnt_d = 1'b1;
          else                                gnt_i = 1'b1;
        end
      end
      ARB_GNT_I: begin
        if (bus.mem_ready) begin
          if (req_d) gnt_d     = 1'b1;
          else       state_nxt = ARB_IDLE;
        end
      end
      ARB_GNT_D: begin
        if (bus.mem_ready) begin
          if (req_i) gnt_i     = 1'b1;
          else       state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
    if (gnt_i) state_nxt = ARB_GNT_I;
    if (gnt_d) state_nxt = ARB_GNT_D;
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state    <= ARB_IDLE;
      last_gnt <= LAST_GNT_RST;
      op_wr    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state <= state_nxt;
      if (gnt_i) begin
        last_gnt <= 1'b0;
        op_wr    <= 1'b0;
        addr_q   <= bus.i_mem_addr;
      end
      if (gnt_d) begin
        last_gnt <= 1'b1;
        op_wr    <= bus.d_mem_write;
        addr_q   <= bus.d_mem_addr;
        wdata_q  <= bus.d_mem_wdata;
      end
    end
  end

  // Reset returns the FSM to IDLE, so outputs drop asynchronously and a stale mem_ready is ignored.
  always_comb begin
    busy            = (state == ARB_GNT_I) || (state == ARB_GNT_D);
    bus.mem_read    = busy & ~op_wr;
    bus.mem_write   = busy & op_wr;
    bus.mem_addr    = busy ? addr_q : '0;
    bus.mem_wdata   = (busy && op_wr) ? wdata_q : '0;
    bus.i_mem_ready = (state == ARB_GNT_I) & bus.mem_ready;
    bus.d_mem_ready = (state == ARB_GNT_D) & bus.mem_ready;
    bus.i_mem_rdata = bus.i_mem_ready ? bus.mem_rdata : '0;
    bus.d_mem_rdata = bus.d_mem_ready ? bus.mem_rdata : '0;
  end

endmodule
